xcvr_rx_fifo_drain_ctrl: RTL and testbench
==========================================

# xcvr_rx_fifo_drain_ctrl

Read-side controller for the transceiver test system's dual-clock RX FIFO (128-bit read port, non-show-ahead). It runs entirely in the FIFO read clock domain. It issues `fifo_rdreq` under a software-armed capture window and delivers words to a downstream valid/ready consumer through a 2-entry skid buffer. It supports bounded or continuous capture, graceful stop, flush-and-discard, and status counters for the checker and CSR logic.

## Interface
Parameters:
- `DATA_W`, 128: FIFO read width and output width.
- `CNT_W`, 16: width of word count and status counters.

Ports:
- `clk`, in, 1: FIFO read clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `cfg_start`, in, 1: pulse; begins capture from IDLE or DONE.
- `cfg_stop`, in, 1: pulse; graceful stop from RUN.
- `cfg_flush`, in, 1: pulse; discard FIFO and buffer contents from any state.
- `cfg_word_count`, in, CNT_W: words to capture, sampled on accepted start; 0 means continuous.
- `fifo_rdreq`, out, 1: FIFO read request.
- `fifo_q`, in, DATA_W: FIFO data, valid the cycle after `fifo_rdreq`.
- `fifo_rdempty`, in, 1: FIFO empty.
- `out_data`, out, DATA_W: delivered word.
- `out_valid`, out, 1: `out_data` valid.
- `out_ready`, in, 1: consumer accepts.
- `status_busy`, out, 1: state is RUN, DRAIN or FLUSH.
- `status_done`, out, 1: state is DONE.
- `status_words`, out, CNT_W: words handed off (`out_valid && out_ready`), saturating.
- `status_stall`, out, CNT_W: RUN cycles with `fifo_rdempty=1`, saturating.

## Operation
- States: IDLE, RUN, DRAIN, FLUSH, DONE.
- IDLE/DONE + `cfg_start`: go to RUN. Latch `cfg_word_count`, clear `issued`, `status_words` and `status_stall`.
- RUN: `fifo_rdreq = !fifo_rdempty && (occ + inflight - pop) < 2 && (cnt==0 || issued < cnt)`.
  - `occ` is the skid occupancy (0..2). `inflight` is last cycle's `fifo_rdreq`. `pop` is `out_valid && out_ready`.
  - `issued` increments on each `fifo_rdreq`.
- RUN to DRAIN: on `cfg_stop`, or in the cycle `issued` reaches a nonzero `cnt`. DRAIN issues no `fifo_rdreq`.
- DRAIN to DONE: when `inflight=0`, `occ=0` and no word is being captured. All requested words are delivered before DONE.
- FLUSH is entered on `cfg_flush` from any state. It has priority over start and stop in the same cycle.
  - On entry, skid contents are dropped and `out_valid` goes 0.
  - `fifo_rdreq = !fifo_rdempty` each cycle; returned data is discarded.
  - FLUSH to IDLE: when `fifo_rdempty=1` and `inflight=0`.
- Ignored pulses:
  - `cfg_start` in RUN, DRAIN or FLUSH.
  - `cfg_stop` outside RUN.
  - `cfg_stop` and count-reach in the same cycle: single transition to DRAIN.
- Skid buffer: FIFO order is preserved. A captured word goes to the tail. `out_data` is always the head.
- Counters saturate at all-ones and never wrap.
- `fifo_rdreq` is never asserted while `fifo_rdempty=1` (no underflow reads).

## Timing
- Reset values: state IDLE; `fifo_rdreq`, `out_valid`, `status_busy` and `status_done` all 0; `out_data` 0; all counters 0.
- `fifo_rdreq` is combinational from registered state, `fifo_rdempty` and `out_ready`. All other outputs are registered.
- Latency: `fifo_rdreq` at cycle t; `fifo_q` is captured at the end of t+1; `out_valid` is high at t+2.
- Throughput: 1 word/cycle sustained when the FIFO is non-empty and `out_ready=1`.
- `out_data` and `out_valid` stay stable while `out_valid && !out_ready`.
- `status_done` rises the cycle after the DRAIN exit condition holds.
- Reset mid-operation: immediate return to IDLE; in-flight data is lost. The FIFO itself is not reset by this block.

## Test plan
- Bounded capture: FIFO holds 10 words, `cfg_word_count=4`, `out_ready=1`.
  - Exactly 4 `fifo_rdreq` are issued.
  - Words 0..3 are delivered in order, back-to-back from t+2.
  - `status_words=4`, `status_done=1`, and 6 words remain in the FIFO.
- Backpressure: `cfg_word_count=0`, `out_ready` toggling 1,0,0,1 repeating.
  - No word is lost or duplicated.
  - `occ` never exceeds 2.
  - Output is held stable while stalled.
- Starvation: start with the FIFO empty for 5 cycles, then write 3 words.
  - `status_stall=5` at first data.
  - `fifo_rdreq` is never high while `fifo_rdempty=1`.
- Stop mid-run: `cfg_stop` one cycle after a `fifo_rdreq`, with 1 word in the skid.
  - Both words are delivered.
  - DONE follows within 3 cycles with no further reads.
- Flush: `cfg_flush` during RUN with the skid full and 7 words in the FIFO.
  - `out_valid` drops next cycle.
  - The FIFO is drained to empty and state returns to IDLE.
  - `status_words` is unchanged.
- Async reset asserted mid-RUN.
  - All outputs are 0 and state is IDLE without a clock edge.
  - A subsequent `cfg_start` runs normally.

Source files
------------

// File: rtl/xcvr_rx_fifo_drain_ctrl.sv
// Read-side drain controller for the transceiver RX FIFO: gated read requests,
// 2-entry skid buffer toward a valid/ready consumer, capture window FSM and status counters.
module xcvr_rx_fifo_drain_ctrl #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              cfg_flush,
  input  logic [CNT_W-1:0]  cfg_word_count,
  output logic              fifo_rdreq,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_rdempty,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              status_busy,
  output logic              status_done,
  output logic [CNT_W-1:0]  status_words,
  output logic [CNT_W-1:0]  status_stall
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         occ, occ_nxt;
  logic               inflight;
  logic [DATA_W-1:0]  skid1;
  logic [CNT_W-1:0]   cnt, issued;
  logic               pop, capture, start_acc, cnt_hit;
  logic [2:0]         load;

  assign pop       = out_valid && out_ready;
  // Data requested last cycle lands now; in FLUSH it is simply not captured.
  assign capture   = inflight && (state == S_RUN || state == S_DRAIN);
  assign load      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign start_acc = cfg_start && !cfg_flush && (state == S_IDLE || state == S_DONE);
  assign occ_nxt   = cfg_flush ? 2'd0 : occ + {1'b0, capture} - {1'b0, pop};

  always_comb begin
    fifo_rdreq = 1'b0;
    case (state)
      S_RUN:   fifo_rdreq = !fifo_rdempty && (load < 3'd2) && (cnt == '0 || issued < cnt);
      S_FLUSH: fifo_rdreq = !fifo_rdempty;
      default: fifo_rdreq = 1'b0;
    endcase
    cnt_hit = (cnt != '0) && ((issued + {{(CNT_W-1){1'b0}}, fifo_rdreq}) == cnt);

    state_nxt = state;
    if (cfg_flush) state_nxt = S_FLUSH;
    else begin
      case (state)
        S_IDLE, S_DONE: if (cfg_start) state_nxt = S_RUN;
        S_RUN:          if (cfg_stop || cnt_hit) state_nxt = S_DRAIN;
        S_DRAIN:        if (!inflight && occ == 2'd0) state_nxt = S_DONE;
        S_FLUSH:        if (fifo_rdempty && !inflight) state_nxt = S_IDLE;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      occ          <= 2'd0;
      inflight     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      skid1        <= '0;
      cnt          <= '0;
      issued       <= '0;
      status_busy  <= 1'b0;
      status_done  <= 1'b0;
      status_words <= '0;
      status_stall <= '0;
    end else begin
      state       <= state_nxt;
      inflight    <= fifo_rdreq;
      occ         <= occ_nxt;
      out_valid   <= (occ_nxt != 2'd0);
      status_busy <= (state_nxt == S_RUN || state_nxt == S_DRAIN || state_nxt == S_FLUSH);
      status_done <= (state_nxt == S_DONE);

      if (start_acc) begin
        cnt    <= cfg_word_count;
        issued <= '0;
      end else if (fifo_rdreq && state == S_RUN) begin
        issued <= issued + CNT_W'(1);
      end

      // out_data is the skid head; skid1 holds the second entry when occ==2.
      if (!cfg_flush) begin
        case ({capture, pop})
          2'b11: if (occ == 2'd2) begin
                   out_data <= skid1;
                   skid1    <= fifo_q;
                 end else begin
                   out_data <= fifo_q;
                 end
          2'b10: if (occ == 2'd0) out_data <= fifo_q;
                 else             skid1    <= fifo_q;
          2'b01: if (occ == 2'd2) out_data <= skid1;
          default: ;
        endcase
      end

      if (start_acc)                       status_words <= '0;
      else if (pop && status_words != '1)  status_words <= status_words + CNT_W'(1);

      if (start_acc)                                               status_stall <= '0;
      else if (state == S_RUN && fifo_rdempty && status_stall != '1) status_stall <= status_stall + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_xcvr_rx_fifo_drain_ctrl.sv
// Randomized scoreboard bench: queue-based FIFO model feeds the DUT, a monitor
// checks delivered words in order against words read out of the model.
module tb_xcvr_rx_fifo_drain_ctrl;
  localparam int DW = 128;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_start = 1'b0, cfg_stop = 1'b0, cfg_flush = 1'b0;
  logic [CW-1:0] cfg_word_count = '0;
  logic          fifo_rdreq;
  logic [DW-1:0] fifo_q = '0;
  logic          fifo_rdempty = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          status_busy, status_done;
  logic [CW-1:0] status_words, status_stall;

  xcvr_rx_fifo_drain_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_flush(cfg_flush), .cfg_word_count(cfg_word_count), .fifo_rdreq(fifo_rdreq),
    .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .status_busy(status_busy),
    .status_done(status_done), .status_words(status_words), .status_stall(status_stall)
  );

  always #5 clk = ~clk;

  int            n_chk = 0, n_fail = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int            cyc = 0, reads_s = 0, dels_s = 0, ready_mode = 0;
  int            first_rd = -1, first_del = -1, last_del = -1;
  bit            discard = 1'b1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: sample the request, then apply FIFO model effects and new inputs after the edge.
  task automatic tick(input int nwr);
    logic rd, fl;
    #1;
    rd = fifo_rdreq;
    fl = cfg_flush;
    if (rd) chk("rdreq_while_empty", fifo_rdempty, 1'b0);
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) begin
      fifo_q = fq.pop_front();
      if (!discard && !fl) begin
        exp_q.push_back(fifo_q);
        reads_s++;
        if (first_rd < 0) first_rd = cyc;
      end
    end
    if (fl) begin
      discard = 1'b1;
      exp_q.delete();
    end
    for (int i = 0; i < nwr; i++) fq.push_back(rw());
    fifo_rdempty = (fq.size() == 0);
    cyc++;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    @(negedge clk);
  endtask

  task automatic start_run(input int c);
    reads_s = 0; dels_s = 0; first_rd = -1; first_del = -1; last_del = -1;
    discard = 1'b0;
    cfg_word_count = CW'(c);
    cfg_start = 1'b1;
    tick(0);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name, output int n);
    n = 0;
    while (!status_done && n < bound) begin
      tick(0);
      n++;
    end
    chk(name, status_done, 1'b1);
  endtask

  // Monitor: in-order data, hold-while-stalled, bounded outstanding words.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) prev_stall = 1'b0;
      else begin
        if (prev_stall && !discard) begin
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_data", out_data, prev_data);
        end
        if (!discard) begin
          n_chk++;
          if (reads_s - dels_s > 2) begin
            n_fail++;
            $display("FAIL outstanding: got %0d words buffered, limit 2", reads_s - dels_s);
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_word: got %0h, none expected", out_data);
          end else chk("data_order", out_data, exp_q.pop_front());
          dels_s++;
          if (first_del < 0) first_del = cyc;
          last_del = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, wr, k, c, wb;
    @(negedge clk); @(negedge clk);
    chk("rst_rdreq", fifo_rdreq, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", status_busy, 1'b0);
    chk("rst_done", status_done, 1'b0);
    chk("rst_data", out_data, '0);
    chk("rst_words", status_words, '0);
    chk("rst_stall", status_stall, '0);
    reset = 1'b0;
    @(negedge clk);

    // Bounded capture: 10 words in FIFO, take 4
    ready_mode = 0;
    repeat (10) fq.push_back(rw());
    fifo_rdempty = 1'b0;
    start_run(4);
    chk("bnd_busy", status_busy, 1'b1);
    wait_done(30, "bnd_done", n);
    chk("bnd_reads", reads_s, 4);
    chk("bnd_words", status_words, 4);
    chk("bnd_left", fq.size(), 6);
    chk("bnd_exp_empty", exp_q.size(), 0);
    chk("bnd_latency", first_del, first_rd + 2);
    chk("bnd_b2b", last_del, first_del + 3);
    chk("bnd_not_busy", status_busy, 1'b0);

    // Backpressure, continuous mode, ready pattern 1,0,0,1
    fq.delete(); fifo_rdempty = 1'b1;
    ready_mode = 1;
    start_run(0);
    wr = 0; n = 0;
    while (wr < 20 && n < 200) begin
      k = ($urandom_range(0, 2) != 0) ? 1 : 0;
      tick(k); wr += k; n++;
    end
    n = 0;
    while (dels_s < 20 && n < 200) begin tick(0); n++; end
    chk("bp_dels", dels_s, 20);
    cfg_stop = 1'b1; tick(0); cfg_stop = 1'b0;
    wait_done(10, "bp_done", n);
    chk("bp_words", status_words, 20);
    chk("bp_exp_empty", exp_q.size(), 0);

    // Starvation: 5 empty RUN cycles, then 3 words
    fq.delete(); fifo_rdempty = 1'b1;
    ready_mode = 0;
    start_run(0);
    repeat (4) tick(0);
    tick(3);
    n = 0;
    while (!out_valid && n < 10) begin tick(0); n++; end
    chk("stv_valid", out_valid, 1'b1);
    chk("stv_stall", status_stall, 5);
    n = 0;
    while (dels_s < 3 && n < 10) begin tick(0); n++; end
    chk("stv_dels", dels_s, 3);
    cfg_stop = 1'b1; tick(0); cfg_stop = 1'b0;
    wait_done(10, "stv_done", n);

    // Stop with one word in skid and one in flight
    fq.delete();
    repeat (5) fq.push_back(rw());
    fifo_rdempty = 1'b0;
    ready_mode = 3;
    start_run(0);
    tick(0); tick(0);
    chk("stop_skid_gate", fifo_rdreq, 1'b0);
    chk("stop_valid", out_valid, 1'b1);
    ready_mode = 0;
    cfg_stop = 1'b1; tick(0); cfg_stop = 1'b0;
    wait_done(3, "stop_done_in_3", n);
    chk("stop_reads", reads_s, 2);
    chk("stop_dels", dels_s, 2);
    chk("stop_fifo_left", fq.size(), 3);

    // Flush with skid full and 7 words left in FIFO
    fq.delete();
    repeat (9) fq.push_back(rw());
    fifo_rdempty = 1'b0;
    ready_mode = 3;
    start_run(0);
    repeat (3) tick(0);
    chk("fl_pre_valid", out_valid, 1'b1);
    chk("fl_pre_left", fq.size(), 7);
    wb = int'(status_words);
    ready_mode = 0;
    cfg_flush = 1'b1; tick(0); cfg_flush = 1'b0;
    chk("fl_valid_drop", out_valid, 1'b0);
    n = 0;
    while (status_busy && n < 40) begin tick(0); n++; end
    chk("fl_idle", status_busy, 1'b0);
    chk("fl_done_low", status_done, 1'b0);
    chk("fl_fifo_empty", fq.size(), 0);
    chk("fl_words_kept", status_words, CW'(wb));

    // Randomized bounded captures with random backpressure and arrivals
    for (int it = 0; it < 3; it++) begin
      fq.delete(); fifo_rdempty = 1'b1;
      c = $urandom_range(1, 12);
      ready_mode = 2;
      start_run(c);
      wr = 0; n = 0;
      while (!status_done && n < 400) begin
        k = (wr < c + 3 && $urandom_range(0, 1) == 1) ? 1 : 0;
        tick(k); wr += k; n++;
      end
      chk("rnd_done", status_done, 1'b1);
      chk("rnd_reads", reads_s, c);
      chk("rnd_dels", dels_s, c);
      chk("rnd_words", status_words, CW'(c));
      chk("rnd_left", fq.size(), wr - c);
    end

    // Async reset mid-RUN, then a clean restart
    fq.delete();
    repeat (20) fq.push_back(rw());
    fifo_rdempty = 1'b0;
    ready_mode = 2;
    start_run(0);
    repeat (6) tick(0);
    discard = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("ar_rdreq", fifo_rdreq, 1'b0);
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_busy", status_busy, 1'b0);
    chk("ar_done", status_done, 1'b0);
    chk("ar_data", out_data, '0);
    chk("ar_words", status_words, '0);
    chk("ar_stall", status_stall, '0);
    fq.delete(); exp_q.delete(); fifo_rdempty = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    repeat (5) fq.push_back(rw());
    fifo_rdempty = 1'b0;
    ready_mode = 0;
    start_run(3);
    wait_done(30, "ar_restart_done", n);
    chk("ar_reads", reads_s, 3);
    chk("ar_dels", dels_s, 3);
    chk("ar_words_after", status_words, 3);
    chk("ar_exp_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
